// File: rtl/apb_flash_rcache.sv
// Direct-mapped one-word-per-line read cache in front of an SPI/flash APB slave.
// Flash read hits answer with zero wait states; everything else is forwarded, flash writes error.
module apb_flash_rcache #(
    parameter int unsigned IDX_W     = 4,
    parameter logic [3:0]  FLASH_NIB = 4'h3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    input  logic        flush
);
    localparam int unsigned LINES = 2 ** IDX_W;
    localparam int unsigned TAG_W = 22 - IDX_W;

    typedef enum logic [1:0] {IDLE, FWD_SETUP, FWD_ACCESS, RESP} state_e;

    state_e             state_q;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];
    logic               flash_q;
    logic               in_pready_q, in_pslverr_q, out_psel_q, out_penable_q;
    logic [31:0]        in_prdata_q, out_paddr_q, out_pwdata_q;
    logic [2:0]         out_pprot_q;
    logic               out_pwrite_q;
    logic [3:0]         out_pstrb_q;

    logic               setup, lk_flash, lk_hit, fill_en;
    logic [IDX_W-1:0]   lk_idx, fill_idx;
    logic [TAG_W-1:0]   lk_tag, fill_tag;

    assign setup    = in_psel & ~in_penable;
    assign lk_flash = (in_paddr[31:28] == FLASH_NIB);
    assign lk_idx   = in_paddr[IDX_W+1:2];
    assign lk_tag   = in_paddr[23:IDX_W+2];
    // A flush in the lookup cycle forces a miss, even if the line looked valid.
    assign lk_hit   = lk_flash & ~in_pwrite & ~flush & valid_q[lk_idx]
                    & (tag_mem[lk_idx] == lk_tag);

    assign fill_idx = out_paddr_q[IDX_W+1:2];
    assign fill_tag = out_paddr_q[23:IDX_W+2];
    assign fill_en  = (state_q == FWD_ACCESS) & out_pready & flash_q & ~out_pwrite_q
                    & ~out_pslverr & ~flush;

    always_comb begin
        valid_d = valid_q;
        if (fill_en) valid_d[fill_idx] = 1'b1;
        if (flush)   valid_d = '0;
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= out_prdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            flash_q       <= 1'b0;
            in_pready_q   <= 1'b0;
            in_pslverr_q  <= 1'b0;
            in_prdata_q   <= '0;
            out_psel_q    <= 1'b0;
            out_penable_q <= 1'b0;
            out_paddr_q   <= '0;
            out_pprot_q   <= '0;
            out_pwrite_q  <= 1'b0;
            out_pwdata_q  <= '0;
            out_pstrb_q   <= '0;
        end else begin
            valid_q <= valid_d;
            case (state_q)
                IDLE: if (setup) begin
                    out_paddr_q  <= in_paddr;
                    out_pprot_q  <= in_pprot;
                    out_pwrite_q <= in_pwrite;
                    out_pwdata_q <= in_pwdata;
                    out_pstrb_q  <= in_pstrb;
                    flash_q      <= lk_flash;
                    if (lk_flash && in_pwrite) begin
                        in_prdata_q  <= '0;
                        in_pslverr_q <= 1'b1;
                        in_pready_q  <= 1'b1;
                        state_q      <= RESP;
                    end else if (lk_hit) begin
                        in_prdata_q  <= data_mem[lk_idx];
                        in_pslverr_q <= 1'b0;
                        in_pready_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        out_psel_q <= 1'b1;
                        state_q    <= FWD_SETUP;
                    end
                end
                FWD_SETUP: begin
                    out_penable_q <= 1'b1;
                    state_q       <= FWD_ACCESS;
                end
                FWD_ACCESS: if (out_pready) begin
                    out_psel_q    <= 1'b0;
                    out_penable_q <= 1'b0;
                    in_prdata_q   <= out_prdata;
                    in_pslverr_q  <= out_pslverr;
                    in_pready_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    in_pready_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    in_pready_q   <= 1'b0;
                    out_psel_q    <= 1'b0;
                    out_penable_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign in_pready   = in_pready_q;
    assign in_prdata   = in_prdata_q;
    assign in_pslverr  = in_pslverr_q;
    assign out_paddr   = out_paddr_q;
    assign out_psel    = out_psel_q;
    assign out_penable = out_penable_q;
    assign out_pprot   = out_pprot_q;
    assign out_pwrite  = out_pwrite_q;
    assign out_pwdata  = out_pwdata_q;
    assign out_pstrb   = out_pstrb_q;
endmodule

// File: tb/tb_apb_flash_rcache.sv
// Directed bench for apb_flash_rcache: upstream APB driver plus an inline downstream responder.
module tb_apb_flash_rcache;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr = '0, in_pwdata = '0, in_prdata;
    logic        in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
    logic [2:0]  in_pprot = '0, out_pprot;
    logic [3:0]  in_pstrb = '0, out_pstrb;
    logic        in_pready, in_pslverr;
    logic [31:0] out_paddr, out_pwdata, out_prdata = '0;
    logic        out_psel, out_penable, out_pwrite;
    logic        out_pready = 1'b0, out_pslverr = 1'b0, flush = 1'b0;

    int n_cmp = 0, n_err = 0;

    int          r_lat, r_nfwd, r_psel_seen;
    logic [31:0] r_data, r_faddr, r_fwd;
    logic        r_err, r_fw, r_stable;
    logic [3:0]  r_fst;
    logic [2:0]  r_fprot;

    apb_flash_rcache #(.IDX_W(4), .FLASH_NIB(4'h3)) dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr), .flush(flush)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One upstream transfer; a forwarded access is answered after dsw wait cycles.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input logic [31:0] dsd,
                        input logic dse, input int dsw, input logic fl_fill, input logic fl_setup);
        int acc;
        logic done;
        @(negedge clock);
        in_paddr = a; in_pwrite = w; in_pwdata = wd; in_pstrb = st; in_pprot = pr;
        in_psel = 1'b1; in_penable = 1'b0; flush = fl_setup;
        r_lat = 0; r_nfwd = 0; r_psel_seen = 0; r_stable = 1'b1; acc = 0; done = 1'b0;
        r_data = 'x; r_err = 1'bx;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clock);
            in_penable = 1'b1; flush = 1'b0; out_pready = 1'b0; out_pslverr = 1'b0;
            if (out_psel) r_psel_seen++;
            if (in_pready) begin
                r_lat = c; r_data = in_prdata; r_err = in_pslverr; done = 1'b1;
            end else if (out_psel && !out_penable) begin
                r_nfwd++;
                r_faddr = out_paddr; r_fw = out_pwrite; r_fwd = out_pwdata;
                r_fst = out_pstrb; r_fprot = out_pprot;
            end else if (out_psel && out_penable) begin
                acc++;
                if (out_paddr !== r_faddr || out_pwrite !== r_fw || out_pwdata !== r_fwd ||
                    out_pstrb !== r_fst || out_pprot !== r_fprot) r_stable = 1'b0;
                if (acc > dsw) begin
                    out_pready = 1'b1; out_prdata = dsd; out_pslverr = dse; flush = fl_fill;
                end
            end
        end
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] dsd);
        xfer(a, 1'b0, 32'h0, 4'hF, 3'b000, dsd, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        #3;
        check("rst_pready",  {31'b0, in_pready}, 32'h0);
        check("rst_pslverr", {31'b0, in_pslverr}, 32'h0);
        check("rst_psel_en", {30'b0, out_psel, out_penable}, 32'h0);
        check("rst_prdata",  in_prdata, 32'h0);
        check("rst_paddr",   out_paddr, 32'h0);
        check("rst_pwdata",  out_pwdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // cold miss then zero-wait hit
        rd(32'h3000_0040, 32'hDEAD_BEEF);
        check("t1_miss_nfwd", r_nfwd, 1);
        check("t1_miss_addr", r_faddr, 32'h3000_0040);
        check("t1_miss_data", r_data, 32'hDEAD_BEEF);
        check("t1_miss_lat",  r_lat, 3);
        check("t1_miss_err",  {31'b0, r_err}, 0);
        rd(32'h3000_0040, 32'h0BAD_0BAD);
        check("t1_hit_lat",   r_lat, 1);
        check("t1_hit_data",  r_data, 32'hDEAD_BEEF);
        check("t1_hit_psel",  r_psel_seen, 0);
        rd(32'h3000_0043, 32'h0BAD_0BAD);
        check("t1_lowbits_hit", r_lat, 1);
        check("t1_lowbits_data", r_data, 32'hDEAD_BEEF);

        // conflict on index 0
        rd(32'h3000_0440, 32'h1111_2222);
        check("t2_conf_nfwd", r_nfwd, 1);
        check("t2_conf_data", r_data, 32'h1111_2222);
        rd(32'h3000_0040, 32'hDEAD_BEEF);
        check("t2_reread_nfwd", r_nfwd, 1);
        rd(32'h3000_0044, 32'hCAFE_F00D);
        check("t2_idx1_nfwd", r_nfwd, 1);
        rd(32'h3000_0040, 32'h0BAD_0BAD);
        check("t2_idx0_hit", r_lat, 1);
        check("t2_idx0_data", r_data, 32'hDEAD_BEEF);
        rd(32'h3000_0044, 32'h0BAD_0BAD);
        check("t2_idx1_data", r_data, 32'hCAFE_F00D);

        // writes: SPI register forwarded intact, flash rejected locally
        xfer(32'h1000_0004, 1'b1, 32'h0000_0001, 4'b0101, 3'b010, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        check("t3_wr_nfwd",  r_nfwd, 1);
        check("t3_wr_addr",  r_faddr, 32'h1000_0004);
        check("t3_wr_pwrite", {31'b0, r_fw}, 1);
        check("t3_wr_pwdata", r_fwd, 32'h0000_0001);
        check("t3_wr_pstrb", {28'b0, r_fst}, 32'h5);
        check("t3_wr_pprot", {29'b0, r_fprot}, 32'h2);
        check("t3_wr_err",   {31'b0, r_err}, 0);
        xfer(32'h3000_0000, 1'b1, 32'h1234_5678, 4'hF, 3'b000, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        check("t3_fw_err",   {31'b0, r_err}, 1);
        check("t3_fw_psel",  r_psel_seen, 0);
        check("t3_fw_lat",   r_lat, 1);
        check("t3_fw_data",  r_data, 32'h0);
        rd(32'h1000_0008, 32'hA5A5_0001);
        rd(32'h1000_0008, 32'hA5A5_0002);
        check("t3_spi_nocache_nfwd", r_nfwd, 1);
        check("t3_spi_nocache_data", r_data, 32'hA5A5_0002);

        // long downstream wait with error: no fill
        xfer(32'h3000_0080, 1'b0, 32'h0, 4'hF, 3'b001, 32'h55AA_55AA, 1'b1, 20, 1'b0, 1'b0);
        check("t4_wait_lat",    r_lat, 23);
        check("t4_wait_stable", {31'b0, r_stable}, 1);
        check("t4_wait_err",    {31'b0, r_err}, 1);
        rd(32'h3000_0080, 32'h1234_5678);
        check("t4_after_err_nfwd", r_nfwd, 1);
        check("t4_after_err_data", r_data, 32'h1234_5678);
        rd(32'h3000_0080, 32'h0BAD_0BAD);
        check("t4_filled_hit", r_lat, 1);

        // flush on the fill cycle wins over the fill, data still returned
        xfer(32'h3000_00C0, 1'b0, 32'h0, 4'hF, 3'b000, 32'h0BAD_F00D, 1'b0, 0, 1'b1, 1'b0);
        check("t5_flush_data", r_data, 32'h0BAD_F00D);
        rd(32'h3000_00C0, 32'h7777_0000);
        check("t5_flush_miss_nfwd", r_nfwd, 1);
        rd(32'h3000_0080, 32'h7777_0001);
        check("t5_flush_all_nfwd", r_nfwd, 1);
        // flush during lookup forces a miss on a valid line
        xfer(32'h3000_0080, 1'b0, 32'h0, 4'hF, 3'b000, 32'h7777_0002, 1'b0, 0, 1'b0, 1'b1);
        check("t5_flush_lookup_nfwd", r_nfwd, 1);
        check("t5_flush_lookup_data", r_data, 32'h7777_0002);

        // reset during the downstream access phase
        rd(32'h3000_0040, 32'hDEAD_BEEF);
        rd(32'h3000_0040, 32'h0BAD_0BAD);
        check("t6_prefill_hit", r_lat, 1);
        @(negedge clock);
        in_paddr = 32'h3000_0100; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        @(negedge clock);
        check("t6_in_access", {30'b0, out_psel, out_penable}, 32'h3);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_psel", {30'b0, out_psel, out_penable}, 32'h0);
        @(negedge clock);
        in_psel = 1'b0; in_penable = 1'b0;
        reset = 1'b1;
        rd(32'h3000_0040, 32'h9999_8888);
        check("t6_post_rst_nfwd", r_nfwd, 1);
        check("t6_post_rst_data", r_data, 32'h9999_8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
